multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
//  Parametrised multicycle control sequencer for the ARM datapath; owns the PC and the instruction register.
//  Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
//  Skips stages by instruction class and stalls on instruction/data memory ready handshakes.
//  Squashes condition-failed instructions and enters a sticky FAULT on a data-memory timeout.
//  Sits between instructionMemory/data memory and the register file, ALU and flag register strobes.
// PARAMETERS
//  ADDR_W       32  PC / imem_addr width
//  RESET_PC     0   PC value loaded on reset
//  MEM_TIMEOUT  15  max cycles in MEM without dmem_ready before FAULT (>=1)
//  CNT_W        32  width of retired-instruction counter
// PORTS
//  clk           in   1       clock
//  nreset        in   1       reset, synchronous, active-high
//  imem_addr     out  ADDR_W  current PC, drives instruction memory
//  imem_ready    in   1       instr valid this cycle
//  instr         in   32      instruction word from instruction memory
//  cond_pass     in   1       condition test result for ir[31:28], sampled in DECODE
//  ir            out  32      latched instruction
//  alu_en        out  1       ALU operate strobe (EXEC)
//  cpsr_we       out  1       flag register write strobe
//  dmem_req      out  1       data memory request, held until dmem_ready
//  dmem_we       out  1       1=store (STR), 0=load; valid while dmem_req
//  dmem_ready    in   1       data memory done
//  rf_we         out  1       register file write strobe
//  rf_link       out  1       with rf_we: write R14 (BL link) instead of rd
//  state         out  3       FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 FAULT=5
//  retire        out  1       1-cycle pulse in final cycle of each instruction
//  fault         out  1       sticky; high while in FAULT
//  retired_cnt   out  CNT_W   count of retire pulses, wraps mod 2^CNT_W
// BEHAVIOUR
//  Reset: state=FETCH, pc=RESET_PC, ir=0, retired_cnt=0, fault=0, wait counter=0; all strobes 0.
//   Reset in any state (incl. MEM, FAULT) takes effect next edge; dmem_req drops next cycle.
//  Strobes are Moore decodes of state+ir (retire also uses cond_pass/dmem_ready).
//  Class from ir: [27:25]=101 branch (L=ir[24]); [27:26]=01 load/store (L=ir[20]); [27:26]=00 data-proc.
//   Compare = data-proc with opcode ir[24:21] in 1000..1011.
//  FETCH:  imem_addr=pc. Waits while !imem_ready.
//          On imem_ready: ir<=instr, pc<=pc+4, ->DECODE.
//  DECODE: 1 cycle. If !cond_pass: retire, ->FETCH (squash, no strobes); else ->EXEC.
//  EXEC:   1 cycle, alu_en=1; cpsr_we=ir[20] for data-proc.
//    branch: pc<=pc+4+(sext(ir[23:0])<<2), i.e. instr addr+8, mod 2^ADDR_W.
//            L=1 ->WB with rf_link=1; L=0 retire ->FETCH.
//    compare: retire ->FETCH. Other data-proc ->WB.
//    load/store: ->MEM.
//  MEM:    dmem_req=1, dmem_we=~L; wait counter increments each cycle without dmem_ready.
//    dmem_ready: store retires ->FETCH; load ->WB. Counter clears.
//    counter reaches MEM_TIMEOUT with no ready: ->FAULT.
//  WB:     rf_we=1 for exactly 1 cycle, retire, ->FETCH.
//  FAULT:  fault=1, all strobes 0, pc frozen; exit only via reset.
//  Undefined state encodings (6,7) ->FAULT.
//  Cycle counts with no stalls:
//    data-proc 4; compare 3; store 4; load 5; B 3; BL 4; squashed 2.
// TESTING
//  T1 reset, imem_ready=1, instr=E0821003 (ADD) -> state 0,1,2,4,0; rf_we one cycle; pc 0->4; retired_cnt=1.
//  T2 instr=EA000002 (B +2) at pc=0 -> pc=0x10 after EXEC, retire in EXEC, rf_we never set.
//  T3 instr=EB000000 (BL) at pc=8 -> pc=0x10, WB rf_we=1 rf_link=1.
//     Then cond_pass=0 on next instr -> DECODE->FETCH in 2 cycles, retire=1, no alu_en.
//  T4 LDR E5912000, dmem_ready after 3 stall cycles -> dmem_req high 4 cycles, dmem_we=0, then WB rf_we.
//     STR E5812000 -> no WB, retire in MEM.
//  T5 LDR with dmem_ready held 0 -> FAULT after MEM_TIMEOUT cycles, fault=1, pc frozen.
//     Then nreset=1 one cycle -> state 0, pc=RESET_PC, fault=0.
//  T6 imem_ready=0 for 5 cycles in FETCH -> state stays 0, pc unchanged.
//     Also: retired_cnt with CNT_W=4 wraps 15->0.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: owns the PC and instruction register and steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB, stalling on memory handshakes.
module multicycle_sequencer #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                MEM_TIMEOUT = 15,
    parameter int                CNT_W       = 32
) (
    input  logic              clk,
    input  logic              nreset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       instr,
    input  logic              cond_pass,
    output logic [31:0]       ir,
    output logic              alu_en,
    output logic              cpsr_we,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ready,
    output logic              rf_we,
    output logic              rf_link,
    output logic [2:0]        state,
    output logic              retire,
    output logic              fault,
    output logic [CNT_W-1:0]  retired_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t             r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [31:0]        r_ir;
    logic [WAIT_W-1:0]  r_wait;
    logic [CNT_W-1:0]   r_retired;

    logic               w_branch;
    logic               w_link;
    logic               w_ldst;
    logic               w_load;
    logic               w_dproc;
    logic               w_compare;
    logic               w_exec_done;
    logic signed [31:0] w_offset;
    logic [ADDR_W-1:0]  w_target;
    logic               w_retire;

    // Instruction class decode from the latched IR
    assign w_branch    = (r_ir[27:25] == 3'b101);
    assign w_link      = r_ir[24];
    assign w_ldst      = (r_ir[27:26] == 2'b01);
    assign w_load      = r_ir[20];
    assign w_dproc     = (r_ir[27:26] == 2'b00);
    assign w_compare   = w_dproc && (r_ir[24:23] == 2'b10);

    // EXEC finishes the instruction for B, compares and any unrecognised class
    assign w_exec_done = w_branch ? !w_link : !(w_ldst || (w_dproc && !w_compare));

    // PC already holds instruction address + 4, so one more +4 gives the ARM +8 base
    assign w_offset    = {{6{r_ir[23]}}, r_ir[23:0], 2'b00};
    assign w_target    = r_pc + ADDR_W'(4) + ADDR_W'(w_offset);

    assign w_retire    = ((r_state == S_DECODE) && !cond_pass)
                       || ((r_state == S_EXEC) && w_exec_done)
                       || ((r_state == S_MEM) && dmem_ready && !w_load)
                       || (r_state == S_WB);

    assign imem_addr   = r_pc;
    assign ir          = r_ir;
    assign state       = r_state;
    assign alu_en      = (r_state == S_EXEC);
    assign cpsr_we     = (r_state == S_EXEC) && w_dproc && r_ir[20];
    assign dmem_req    = (r_state == S_MEM);
    assign dmem_we     = (r_state == S_MEM) && !w_load;
    assign rf_we       = (r_state == S_WB);
    assign rf_link     = (r_state == S_WB) && w_branch && w_link;
    assign retire      = w_retire;
    assign fault       = (r_state == S_FAULT);
    assign retired_cnt = r_retired;

    always_ff @(posedge clk) begin
        if (nreset) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_wait    <= '0;
            r_retired <= '0;
        end else begin
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            case (r_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        r_ir    <= instr;
                        r_pc    <= r_pc + ADDR_W'(4);
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_state <= cond_pass ? S_EXEC : S_FETCH;
                end
                S_EXEC: begin
                    if (w_branch) begin
                        r_pc    <= w_target;
                        r_state <= w_link ? S_WB : S_FETCH;
                    end else if (w_ldst) begin
                        r_state <= S_MEM;
                    end else if (w_dproc && !w_compare) begin
                        r_state <= S_WB;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                // Wait counter only advances on cycles without a data-memory response
                S_MEM: begin
                    if (dmem_ready) begin
                        r_wait  <= '0;
                        r_state <= w_load ? S_WB : S_FETCH;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                        if (r_wait == WAIT_LAST) begin
                            r_state <= S_FAULT;
                        end
                    end
                end
                S_WB: begin
                    r_state <= S_FETCH;
                end
                S_FAULT: begin
                    r_state <= S_FAULT;
                end
                default: begin
                    r_state <= S_FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: directed instructions push their expected
// per-instruction profile; an independent monitor pops and compares on every retire pulse.
module tb_multicycle_sequencer;

    localparam int         MEM_TIMEOUT = 15;
    localparam int         CNT_W       = 4;
    localparam logic [2:0] ST_FETCH    = 3'd0;
    localparam logic [2:0] ST_DECODE   = 3'd1;
    localparam logic [2:0] ST_EXEC     = 3'd2;
    localparam logic [2:0] ST_MEM      = 3'd3;
    localparam logic [2:0] ST_WB       = 3'd4;
    localparam logic [2:0] ST_FAULT    = 3'd5;

    logic             clk = 1'b0;
    logic             nreset;
    logic [31:0]      imem_addr;
    logic             imem_ready;
    logic [31:0]      instr;
    logic             cond_pass;
    logic [31:0]      ir;
    logic             alu_en;
    logic             cpsr_we;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_ready;
    logic             rf_we;
    logic             rf_link;
    logic [2:0]       state;
    logic             retire;
    logic             fault;
    logic [CNT_W-1:0] retired_cnt;

    multicycle_sequencer #(
        .ADDR_W      (32),
        .RESET_PC    (32'h0),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .nreset      (nreset),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .instr       (instr),
        .cond_pass   (cond_pass),
        .ir          (ir),
        .alu_en      (alu_en),
        .cpsr_we     (cpsr_we),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ready  (dmem_ready),
        .rf_we       (rf_we),
        .rf_link     (rf_link),
        .state       (state),
        .retire      (retire),
        .fault       (fault),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               cycles;
        logic [2:0]       retState;
        int               alu;
        int               rfwe;
        int               link;
        int               dmem;
        int               dmemWe;
        int               cpsr;
        logic [31:0]      nextPc;
        logic [CNT_W-1:0] cntAfter;
    } exp_t;

    exp_t             scoreboard[$];
    int               nChecks = 0;
    int               nPass   = 0;
    logic [31:0]      expPc;
    logic [CNT_W-1:0] expCnt;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Monitor: accumulates strobe counts over the non-FETCH cycles of each instruction
    int               nfCycles, aluCnt, rfweCnt, linkCnt, dmemCnt, dmemWeCnt, cpsrCnt;
    bit               pending = 1'b0;
    logic [31:0]      pendPc;
    logic [CNT_W-1:0] pendCnt;
    exp_t             e;

    always begin
        @(negedge clk);
        #1;
        if (pending) begin
            checkOutput("pcAfterRetire", imem_addr, pendPc);
            checkOutput("retiredCnt", retired_cnt, pendCnt);
            pending = 1'b0;
        end
        if (state == ST_FETCH) begin
            nfCycles = 0; aluCnt = 0; rfweCnt = 0; linkCnt = 0;
            dmemCnt = 0; dmemWeCnt = 0; cpsrCnt = 0;
        end else begin
            nfCycles++;
            aluCnt    += alu_en ? 1 : 0;
            rfweCnt   += rf_we ? 1 : 0;
            linkCnt   += (rf_we && rf_link) ? 1 : 0;
            dmemCnt   += dmem_req ? 1 : 0;
            dmemWeCnt += (dmem_req && dmem_we) ? 1 : 0;
            cpsrCnt   += cpsr_we ? 1 : 0;
            if (retire) begin
                if (scoreboard.size() == 0) begin
                    nChecks++;
                    $display("[TB] FAIL unexpectedRetire: retire seen in state %0d with nothing expected", state);
                end else begin
                    e = scoreboard.pop_front();
                    checkOutput("instrCycles", nfCycles + 1, e.cycles);
                    checkOutput("retireState", state, e.retState);
                    checkOutput("aluEnCycles", aluCnt, e.alu);
                    checkOutput("rfWeCycles", rfweCnt, e.rfwe);
                    checkOutput("rfLinkCycles", linkCnt, e.link);
                    checkOutput("dmemReqCycles", dmemCnt, e.dmem);
                    checkOutput("dmemWeCycles", dmemWeCnt, e.dmemWe);
                    checkOutput("cpsrWeCycles", cpsrCnt, e.cpsr);
                    pendPc  = e.nextPc;
                    pendCnt = e.cntAfter;
                    pending = 1'b1;
                end
            end
        end
    end

    // Presents one instruction and plays data memory until the DUT is back in FETCH or FAULT
    task automatic driveInstr(input logic [31:0] word, input bit cond, input int memDelay,
                              input int abortAt, output int memCycles);
        bit done;
        done      = 1'b0;
        memCycles = 0;
        @(negedge clk);
        instr      = word;
        cond_pass  = cond;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            imem_ready = 1'b0;
            dmem_ready = 1'b0;
            if (state == ST_FETCH || state == ST_FAULT) begin
                done = 1'b1;
            end else if (state == ST_MEM) begin
                if (memCycles == abortAt) begin
                    nreset = 1'b1;
                    done   = 1'b1;
                end else begin
                    dmem_ready = (memCycles == memDelay);
                    memCycles++;
                end
            end
        end
        if (!done) begin
            nChecks++;
            $display("[TB] FAIL instrTimeout: instr 0x%08h never completed, state %0d", word, state);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] word, input bit cond, input int memDelay,
                                 input int cycles, input logic [2:0] retState, input int alu,
                                 input int rfwe, input int link, input int dmem, input int dmemWe,
                                 input int cpsr, input logic [31:0] nextPc);
        exp_t x;
        int   memCycles;
        expCnt     = expCnt + CNT_W'(1);
        expPc      = nextPc;
        x.cycles   = cycles;
        x.retState = retState;
        x.alu      = alu;
        x.rfwe     = rfwe;
        x.link     = link;
        x.dmem     = dmem;
        x.dmemWe   = dmemWe;
        x.cpsr     = cpsr;
        x.nextPc   = nextPc;
        x.cntAfter = expCnt;
        scoreboard.push_back(x);
        driveInstr(word, cond, memDelay, -1, memCycles);
    endtask

    task automatic checkReset();
        checkOutput("resetState", state, ST_FETCH);
        checkOutput("resetPc", imem_addr, 32'h0);
        checkOutput("resetIr", ir, 32'h0);
        checkOutput("resetFault", fault, 1'b0);
        checkOutput("resetRetiredCnt", retired_cnt, 0);
        checkOutput("resetStrobes", {alu_en, cpsr_we, dmem_req, rf_we, rf_link, retire}, 6'b0);
    endtask

    task automatic doReset();
        @(negedge clk);
        nreset     = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        cond_pass  = 1'b1;
        instr      = 32'h0;
        @(negedge clk);
        checkReset();
        nreset = 1'b0;
        expPc  = 32'h0;
        expCnt = '0;
    endtask

    initial begin
        int memCycles;
        nreset     = 1'b1;
        imem_ready = 1'b0;
        instr      = 32'h0;
        cond_pass  = 1'b1;
        dmem_ready = 1'b0;
        @(negedge clk);
        checkReset();
        nreset = 1'b0;
        expPc  = 32'h0;
        expCnt = '0;

        //            word          cond mem cyc state     alu rfwe lnk dmem dwe cpsr nextPc
        applyStimulus(32'hE0821003, 1, -1, 4, ST_WB,     1, 1, 0, 0, 0, 0, 32'h04); // ADD
        applyStimulus(32'hE1530004, 1, -1, 3, ST_EXEC,   1, 0, 0, 0, 0, 1, 32'h08); // CMP
        applyStimulus(32'hEB000000, 1, -1, 4, ST_WB,     1, 1, 1, 0, 0, 0, 32'h10); // BL
        applyStimulus(32'hE0821003, 0, -1, 2, ST_DECODE, 0, 0, 0, 0, 0, 0, 32'h14); // squashed
        applyStimulus(32'hE5912000, 1,  3, 8, ST_WB,     1, 1, 0, 4, 0, 0, 32'h18); // LDR, 3 stalls
        applyStimulus(32'hE5812000, 1,  0, 4, ST_MEM,    1, 0, 0, 1, 1, 0, 32'h1C); // STR
        applyStimulus(32'hE0921003, 1, -1, 4, ST_WB,     1, 1, 0, 0, 0, 1, 32'h20); // ADDS
        applyStimulus(32'hEAFFFFF8, 1, -1, 3, ST_EXEC,   1, 0, 0, 0, 0, 0, 32'h08); // B backward
        applyStimulus(32'hE5812000, 1,  2, 6, ST_MEM,    1, 0, 0, 3, 3, 0, 32'h0C); // STR, 2 stalls

        doReset();
        applyStimulus(32'hEA000002, 1, -1, 3, ST_EXEC,   1, 0, 0, 0, 0, 0, 32'h10); // B +2
        // Fifteen more retires take the 4-bit counter from 1 through 15 and back to 0
        for (int i = 0; i < 15; i++) begin
            applyStimulus(32'hE0821003, 0, -1, 2, ST_DECODE, 0, 0, 0, 0, 0, 0, 32'h14 + 32'(4 * i));
        end

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            imem_ready = 1'b0;
            checkOutput("stallState", state, ST_FETCH);
            checkOutput("stallPc", imem_addr, 32'h4C);
        end

        driveInstr(32'hE5912000, 1'b1, -1, -1, memCycles);
        checkOutput("timeoutMemCycles", memCycles, MEM_TIMEOUT);
        for (int i = 0; i < 3; i++) begin
            checkOutput("faultState", state, ST_FAULT);
            checkOutput("faultFlag", fault, 1'b1);
            checkOutput("faultPcFrozen", imem_addr, 32'h50);
            checkOutput("faultStrobes", {alu_en, cpsr_we, dmem_req, rf_we, retire}, 5'b0);
            @(negedge clk);
        end
        doReset();

        driveInstr(32'hE5912000, 1'b1, -1, 2, memCycles);
        @(negedge clk);
        checkOutput("abortMemCycles", memCycles, 2);
        checkOutput("abortDmemReq", dmem_req, 1'b0);
        checkOutput("abortState", state, ST_FETCH);
        checkOutput("abortPc", imem_addr, 32'h0);
        nreset = 1'b0;
        expPc  = 32'h0;
        expCnt = '0;
        applyStimulus(32'hE0821003, 1, -1, 4, ST_WB,     1, 1, 0, 0, 0, 0, 32'h04);

        repeat (2) @(negedge clk);
        checkOutput("scoreboardDrained", scoreboard.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed", nPass, nChecks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
